// File: rtl/ahb_wait_state_slave.sv
// AHB slave in front of a word-addressed SRAM: fixed wait states on OKAY, two-cycle ERROR otherwise.
// Optional macro AHB_SLV_UNALIGNED_ERR_EN turns misaligned halfword/word accesses into ERROR.
module ahb_wait_state_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic                  hclk_i,
  input  logic                  hreset_i,
  input  logic                  hsel_i,
  input  logic [ADDR_WIDTH-1:0] haddr_i,
  input  logic [1:0]            htrans_i,
  input  logic                  hwrite_i,
  input  logic [2:0]            hsize_i,
  input  logic [2:0]            hburst_i,
  input  logic                  hmastlock_i,
  input  logic [DATA_WIDTH-1:0] hwdata_i,
  input  logic                  hready_i,
  output logic                  hreadyout_o,
  output logic [1:0]            hresp_o,
  output logic [DATA_WIDTH-1:0] hrdata_o
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(4 * MEM_DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t                state_q;
  logic [3:0]            cnt_q;
  logic                  hreadyout_q;
  logic [1:0]            hresp_q;
  logic [DATA_WIDTH-1:0] hrdata_q;
  logic                  write_q;
  logic [IDX_W-1:0]      idx_q;
  logic [3:0]            be_q;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic                  accept_d;
  logic                  err_d;
  logic                  commit_d;
  logic [IDX_W-1:0]      idx_d;
  logic [3:0]            be_d;
  logic [DATA_WIDTH-1:0] merge_d;
  logic [DATA_WIDTH-1:0] fwd_d;

  logic unused_inputs;
  assign unused_inputs = ^{hburst_i, hmastlock_i};

  // Address-phase decode.
  always_comb begin
    accept_d = hsel_i & hready_i & htrans_i[1];
    idx_d    = haddr_i[IDX_W+1:2];
    err_d    = (haddr_i >= MEM_BYTES) || (hsize_i > 3'b010);
`ifdef AHB_SLV_UNALIGNED_ERR_EN
    err_d    = err_d || (hsize_i == 3'b001 && haddr_i[0])
                     || (hsize_i == 3'b010 && haddr_i[1:0] != 2'b00);
`endif
    case (hsize_i)
      3'b000:  be_d = 4'b0001 << haddr_i[1:0];
      3'b001:  be_d = haddr_i[1] ? 4'b1100 : 4'b0011;
      default: be_d = 4'b1111;
    endcase
  end

  // A write commits as DONE ends; a pipelined read of the same word sees the merged bytes.
  always_comb begin
    commit_d = (state_q == S_DONE) && write_q;
    merge_d  = mem_q[idx_q];
    for (int b = 0; b < 4; b++) begin
      if (be_q[b]) merge_d[8*b +: 8] = hwdata_i[8*b +: 8];
    end
    fwd_d = (commit_d && idx_d == idx_q) ? merge_d : mem_q[idx_d];
  end

  always_ff @(posedge hclk_i) begin
    if (!hreset_i && commit_d) mem_q[idx_q] <= merge_d;
  end

  always_ff @(posedge hclk_i) begin
    if (hreset_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= RESP_OKAY;
      hrdata_q    <= '0;
      write_q     <= 1'b0;
      idx_q       <= '0;
      be_q        <= 4'd0;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (cnt_q >= WS) begin
            state_q     <= S_DONE;
            cnt_q       <= 4'd0;
            hreadyout_q <= 1'b1;
            if (!write_q) hrdata_q <= mem_q[idx_q];
          end else begin
            cnt_q <= (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
          end
        end
        S_ERR1: begin
          state_q     <= S_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= RESP_ERROR;
        end
        default: begin
          // IDLE, DONE and ERR2 all decide the next data phase from the current address phase.
          if (accept_d) begin
            idx_q   <= idx_d;
            be_q    <= be_d;
            write_q <= hwrite_i & ~err_d;
            if (err_d) begin
              state_q     <= S_ERR1;
              hreadyout_q <= 1'b0;
              hresp_q     <= RESP_ERROR;
            end else if (WS == 4'd0) begin
              state_q     <= S_DONE;
              hreadyout_q <= 1'b1;
              hresp_q     <= RESP_OKAY;
              if (!hwrite_i) hrdata_q <= fwd_d;
            end else begin
              state_q     <= S_WAIT;
              cnt_q       <= 4'd1;
              hreadyout_q <= 1'b0;
              hresp_q     <= RESP_OKAY;
            end
          end else begin
            state_q     <= S_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= RESP_OKAY;
          end
        end
      endcase
    end
  end

  assign hreadyout_o = hreadyout_q;
  assign hresp_o     = hresp_q;
  assign hrdata_o    = hrdata_q;

endmodule

// File: tb/tb_ahb_wait_state_slave.sv
// Bench for ahb_wait_state_slave: two instances (2 and 0 wait states) checked cycle by cycle
// against a transaction-level model, plus literal expectations for the directed scenarios.
module tb_ahb_wait_state_slave;
  localparam int MEM_DEPTH = 256;

  typedef struct packed {
    logic        rdy;
    logic [1:0]  resp;
    logic        rd_done;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] widx;
    logic [31:0] rdata;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst      [2];
  logic        hsel     [2];
  logic [31:0] haddr    [2];
  logic [1:0]  htrans   [2];
  logic        hwrite   [2];
  logic [2:0]  hsize    [2];
  logic [31:0] hwdata   [2];
  logic        mlock;
  logic        rdyo     [2];
  logic [1:0]  respo    [2];
  logic [31:0] rdatao   [2];
  logic        exp_rdy  [2] = '{1'b1, 1'b1};
  logic [1:0]  exp_resp [2] = '{2'b00, 2'b00};
  logic        nx_rdy   [2];
  logic [1:0]  nx_resp  [2];
  logic [31:0] hold     [2] = '{32'h0, 32'h0};
  logic        acc      [2];
  ent_t        mq       [2][$];
  bit   [7:0]  mm       [2][1024];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic        chk_en = 1'b0;

  always #5 clk = ~clk;

  ahb_wait_state_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(MEM_DEPTH), .WAIT_STATES(2)) dut_ws2 (
    .hclk_i(clk), .hreset_i(rst[0]), .hsel_i(hsel[0]), .haddr_i(haddr[0]), .htrans_i(htrans[0]),
    .hwrite_i(hwrite[0]), .hsize_i(hsize[0]), .hburst_i(3'b000), .hmastlock_i(mlock),
    .hwdata_i(hwdata[0]), .hready_i(exp_rdy[0]), .hreadyout_o(rdyo[0]), .hresp_o(respo[0]),
    .hrdata_o(rdatao[0]));

  ahb_wait_state_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(MEM_DEPTH), .WAIT_STATES(0)) dut_ws0 (
    .hclk_i(clk), .hreset_i(rst[1]), .hsel_i(hsel[1]), .haddr_i(haddr[1]), .htrans_i(htrans[1]),
    .hwrite_i(hwrite[1]), .hsize_i(hsize[1]), .hburst_i(3'b001), .hmastlock_i(mlock),
    .hwdata_i(hwdata[1]), .hready_i(exp_rdy[1]), .hreadyout_o(rdyo[1]), .hresp_o(respo[1]),
    .hrdata_o(rdatao[1]));

  function automatic int ws_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // Transaction model: each accepted transfer expands into one expected entry per data-phase cycle.
  task automatic model_step(input int i);
    ent_t        e;
    logic [31:0] a;
    logic        err;
    acc[i] = 1'b0;
    if (rst[i]) begin
      mq[i].delete();
      hold[i] = 32'h0;
    end else begin
      if (mq[i].size() > 0) begin
        e = mq[i].pop_front();
        if (e.wr)
          for (int b = 0; b < 4; b++)
            if (e.be[b]) mm[i][e.widx*4 + b] = hwdata[i][8*b +: 8];
      end
      if (hsel[i] && exp_rdy[i] && htrans[i][1]) begin
        acc[i] = 1'b1;
        a   = haddr[i];
        err = (a >= 32'(4 * MEM_DEPTH)) || (hsize[i] > 3'd2);
`ifdef AHB_SLV_UNALIGNED_ERR_EN
        err = err || (hsize[i] == 3'd1 && a[0]) || (hsize[i] == 3'd2 && a[1:0] != 2'b00);
`endif
        e = '0;
        if (err) begin
          e.resp = 2'b01;
          mq[i].push_back(e);
          e.rdy = 1'b1;
          mq[i].push_back(e);
        end else begin
          for (int n = 0; n < ws_of(i); n++) mq[i].push_back(e);
          e.rdy     = 1'b1;
          e.widx    = a >> 2;
          e.wr      = hwrite[i];
          e.rd_done = !hwrite[i];
          case (hsize[i])
            3'd0:    e.be = 4'b0001 << a[1:0];
            3'd1:    e.be = a[1] ? 4'b1100 : 4'b0011;
            default: e.be = 4'b1111;
          endcase
          for (int b = 0; b < 4; b++) e.rdata[8*b +: 8] = mm[i][e.widx*4 + b];
          mq[i].push_back(e);
        end
      end
      if (mq[i].size() > 0 && mq[i][0].rd_done) hold[i] = mq[i][0].rdata;
    end
    if (mq[i].size() == 0) begin
      nx_rdy[i]  = 1'b1;
      nx_resp[i] = 2'b00;
    end else begin
      nx_rdy[i]  = mq[i][0].rdy;
      nx_resp[i] = mq[i][0].resp;
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    exp_rdy  <= nx_rdy;
    exp_resp <= nx_resp;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("hreadyout[ws%0d]", ws_of(i)), {31'b0, rdyo[i]}, {31'b0, exp_rdy[i]});
        chk($sformatf("hresp[ws%0d]", ws_of(i)), {30'b0, respo[i]}, {30'b0, exp_resp[i]});
        chk($sformatf("hrdata[ws%0d]", ws_of(i)), rdatao[i], hold[i]);
      end
    end
  end

  task automatic xfer(input int i, input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata);
    int n;
    n = 0;
    hsel[i] = 1'b1; htrans[i] = 2'b10; haddr[i] = addr; hwrite[i] = wr; hsize[i] = size;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!acc[i] && n < 50);
    if (!acc[i]) begin
      total_cnt++;
      $display("FAIL accept_timeout ws%0d addr %h: not accepted, required within 50 cycles", ws_of(i), addr);
    end
    hwdata[i] = wdata; hsel[i] = 1'b0; htrans[i] = 2'b00;
  endtask

  task automatic finish_xfer(input int i, output logic [31:0] rdata, output int lowcnt,
                             output logic [1:0] resp);
    lowcnt = 0; rdata = '0; resp = 2'b11;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rdyo[i] === 1'b1) begin
        rdata = rdatao[i];
        resp  = respo[i];
        return;
      end
      lowcnt++;
    end
    total_cnt++;
    $display("FAIL done_timeout ws%0d: hreadyout stayed low, required high within 50 cycles", ws_of(i));
  endtask

  task automatic run(input int i, input logic wr, input logic [31:0] addr, input logic [2:0] size,
                     input logic [31:0] wdata, output logic [31:0] rdata, output int lowcnt,
                     output logic [1:0] resp);
    xfer(i, wr, addr, size, wdata);
    finish_xfer(i, rdata, lowcnt, resp);
  endtask

  logic [31:0] rd;
  int          lc;
  logic [1:0]  rs;

  initial begin
    mlock = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; hsel[i] = 1'b0; haddr[i] = '0; htrans[i] = 2'b00;
      hwrite[i] = 1'b0; hsize[i] = 3'd2; hwdata[i] = '0;
    end
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    chk("reset_hreadyout", {31'b0, rdyo[0]}, 32'h1);
    chk("reset_hresp", {30'b0, respo[0]}, 32'h0);
    chk("reset_hrdata", rdatao[1], 32'h0);

    // Two wait states: write then read back.
    run(0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, rd, lc, rs);
    chk("ws2_write_low_cycles", lc, 32'd2);
    chk("ws2_write_resp", {30'b0, rs}, 32'h0);
    run(0, 1'b0, 32'h10, 3'd2, 32'h0, rd, lc, rs);
    chk("ws2_read_data", rd, 32'hDEADBEEF);
    chk("ws2_read_low_cycles", lc, 32'd2);

    // Read queued behind a write while hready is low.
    xfer(0, 1'b1, 32'h40, 3'd2, 32'h01020304);
    run(0, 1'b0, 32'h40, 3'd2, 32'h0, rd, lc, rs);
    chk("ws2_stalled_read", rd, 32'h01020304);

    run(0, 1'b1, 32'h400, 3'd2, 32'h55, rd, lc, rs);
    chk("ws2_oor_low_cycles", lc, 32'd1);
    chk("ws2_oor_resp", {30'b0, rs}, 32'h1);

    // Reset during the second wait cycle of a write.
    run(0, 1'b1, 32'h0, 3'd2, 32'hCAFEF00D, rd, lc, rs);
    xfer(0, 1'b1, 32'h0, 3'd2, 32'h55);
    @(posedge clk); #1;
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    @(negedge clk);
    chk("reset_mid_hreadyout", {31'b0, rdyo[0]}, 32'h1);
    run(0, 1'b0, 32'h0, 3'd2, 32'h0, rd, lc, rs);
    chk("reset_mid_mem_kept", rd, 32'hCAFEF00D);

    // Zero wait states: forwarding across back-to-back write/read.
    run(1, 1'b1, 32'h20, 3'd2, 32'h11223344, rd, lc, rs);
    xfer(1, 1'b1, 32'h21, 3'd0, 32'h0000AA00);
    run(1, 1'b0, 32'h20, 3'd2, 32'h0, rd, lc, rs);
    chk("ws0_forward_byte", rd, 32'h1122AA44);
    chk("ws0_read_low_cycles", lc, 32'd0);
    xfer(1, 1'b1, 32'h23, 3'd0, 32'h77000000);
    run(1, 1'b0, 32'h20, 3'd2, 32'h0, rd, lc, rs);
    chk("ws0_forward_top_byte", rd, 32'h7722AA44);

    mlock = 1'b1;
    run(1, 1'b1, 32'h0, 3'd2, 32'hA5A5A5A5, rd, lc, rs);
    mlock = 1'b0;
    run(1, 1'b1, 32'h400, 3'd2, 32'hFFFFFFFF, rd, lc, rs);
    chk("ws0_oor_low_cycles", lc, 32'd1);
    chk("ws0_oor_resp", {30'b0, rs}, 32'h1);
    run(1, 1'b0, 32'h0, 3'd2, 32'h0, rd, lc, rs);
    chk("ws0_oor_no_write", rd, 32'hA5A5A5A5);

    run(1, 1'b1, 32'h2, 3'd1, 32'hBEEF0000, rd, lc, rs);
    run(1, 1'b1, 32'h3, 3'd1, 32'h12340000, rd, lc, rs);
    run(1, 1'b1, 32'h4, 3'd2, 32'h01010101, rd, lc, rs);
    run(1, 1'b1, 32'h5, 3'd2, 32'h0BADCAFE, rd, lc, rs);
`ifdef AHB_SLV_UNALIGNED_ERR_EN
    chk("unaligned_word_resp", {30'b0, rs}, 32'h1);
    run(1, 1'b0, 32'h0, 3'd2, 32'h0, rd, lc, rs);
    chk("halfword_unaligned_err", rd, 32'hBEEFA5A5);
    run(1, 1'b0, 32'h4, 3'd2, 32'h0, rd, lc, rs);
    chk("word_unaligned_err", rd, 32'h01010101);
`else
    chk("unaligned_word_resp", {30'b0, rs}, 32'h0);
    run(1, 1'b0, 32'h0, 3'd2, 32'h0, rd, lc, rs);
    chk("halfword_unaligned_ok", rd, 32'h1234A5A5);
    run(1, 1'b0, 32'h4, 3'd2, 32'h0, rd, lc, rs);
    chk("word_unaligned_ok", rd, 32'h0BADCAFE);
`endif

    run(1, 1'b0, 32'h8, 3'd3, 32'h0, rd, lc, rs);
    chk("bad_hsize_resp", {30'b0, rs}, 32'h1);
    chk("bad_hsize_low_cycles", lc, 32'd1);

    // Selected without a transfer, then a transfer while unselected.
    hsel[1] = 1'b1; haddr[1] = 32'h20; htrans[1] = 2'b01;
    repeat (3) @(negedge clk);
    htrans[1] = 2'b00;
    repeat (2) @(negedge clk);
    hsel[1] = 1'b0; htrans[1] = 2'b10;
    repeat (2) @(negedge clk);
    htrans[1] = 2'b00;
    chk("idle_busy_hreadyout", {31'b0, rdyo[1]}, 32'h1);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ahb_wait_state_slave.md
# ahb_wait_state_slave

AHB slave responder backing a word-addressed internal SRAM, answering master-driven transfers with a configurable number of wait states and a two-cycle ERROR response for out-of-range accesses. It is the responder end of the AHB transfers the bus-level coverage exercises:

- single and back-to-back reads and writes;
- default-slave-style IDLE handling;
- reset mid-transfer;
- locked writes.

It sits behind the AHB decoder/mux as a selectable slave.

## Interface
- ADDR_WIDTH, 32, HADDR width
- DATA_WIDTH, 32, HWDATA/HRDATA width (fixed 32 in this block)
- MEM_DEPTH, 256, number of 32-bit words; valid byte addresses 0 .. 4*MEM_DEPTH-1
- WAIT_STATES, 1, wait cycles inserted per OKAY data phase (0..15)
- HCLK  in  1  clock; one clock, all logic on rising edge
- HRESET  in  1  reset, synchronous, active-high
- HSEL  in  1  slave select
- HADDR  in  ADDR_WIDTH  address
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HWRITE  in  1  1=write
- HSIZE  in  3  000 byte, 001 halfword, 010 word; others → ERROR
- HBURST  in  3  accepted, not interpreted
- HMASTLOCK  in  1  accepted, not interpreted
- HWDATA  in  32  write data (data phase)
- HREADY  in  1  bus-level ready (mux output)
- HREADYOUT  out  1  slave ready
- HRESP  out  2  OKAY=00, ERROR=01
- HRDATA  out  32  read data

## Operation
- Transfer accepted when HSEL & HREADY & HTRANS[1] are all high at a rising edge. The edge latches the address, write flag and size into the data-phase registers.
- IDLE/BUSY, or unselected: no data phase is started. Any subsequent cycle the slave is addressed without a transfer gives HREADYOUT=1, HRESP=OKAY.
- Error condition: word index ≥ MEM_DEPTH, or HSIZE > 010.
- States:
  - IDLE: no pending data phase.
  - WAIT: counter running, HREADYOUT=0, HRESP=OKAY.
  - DONE: HREADYOUT=1, HRESP=OKAY.
  - ERR1: HREADYOUT=0, HRESP=ERROR.
  - ERR2: HREADYOUT=1, HRESP=ERROR.
- Transitions:
  - Accept, OKAY, WAIT_STATES>0 → WAIT.
  - Accept, OKAY, WAIT_STATES=0 → DONE.
  - Accept, error → ERR1.
  - WAIT → DONE when the counter reaches WAIT_STATES.
  - ERR1 → ERR2.
  - DONE/ERR2 → next state decided by accept in the same cycle (pipelined), else IDLE.
- Writes commit at the end of the DONE cycle using HWDATA with little-endian byte lanes:
  - byte: lane HADDR[1:0];
  - halfword: lanes {HADDR[1],0},+1;
  - word: all four lanes.
- Errored writes never modify memory.
- Reads: HRDATA holds the full addressed word, valid during DONE. It is loaded at the edge entering DONE.
- Read-after-write forwarding: if the pending write commits on the same edge HRDATA is loaded for the same word, HRDATA reflects the merged new bytes.
- HRDATA holds its last value outside DONE.

## Timing
- Reset values: HREADYOUT=1, HRESP=00, HRDATA=0, state IDLE, wait counter 0.
- Memory contents are not cleared by reset.
- Reset mid-data-phase: the transfer is abandoned, no write commits, and outputs return to reset values on the next cycle.
- Address phase at cycle N:
  - OKAY: HREADYOUT low N+1 .. N+WAIT_STATES, high at N+1+WAIT_STATES (the completion cycle).
  - ERROR: ERR1 at N+1, ERR2 at N+2, regardless of WAIT_STATES.
- Back-to-back: an accept in the completion cycle starts the next data phase on the following cycle.
  - With WAIT_STATES=0, one transfer completes per cycle.
- During HREADY=0 (this or another slave stalling) no new transfer is accepted. Address/control are not resampled.
- Wait counter is 4 bits and saturates; WAIT_STATES>15 is illegal.

## Configuration
- AHB_SLV_UNALIGNED_ERR_EN:
  - Defined: a halfword with HADDR[0]=1, or a word with HADDR[1:0]≠00, is an error condition (ERR1/ERR2, no write).
  - Undefined: the offending low address bits are forced to 0 and the transfer completes OKAY.

## Test plan
- Reset: HRESET high 2 cycles → HREADYOUT=1, HRESP=00, HRDATA=0 the cycle after reset.
- WAIT_STATES=2, word write 0xDEADBEEF @0x10 then read @0x10:
  - HREADYOUT low 2 cycles per transfer, HRESP=00.
  - Read returns 0xDEADBEEF.
- WAIT_STATES=0, byte write 0xAA @0x21 immediately followed by word read @0x20, with prior word 0x11223344 → read returns 0x1122AA44 (forwarding).
- Out-of-range write @4*MEM_DEPTH:
  - HRESP=01 two cycles, HREADYOUT 0 then 1.
  - A subsequent read of word 0 is unchanged.
- Reset asserted in the second wait cycle of a word write 0x55 @0x0 → memory @0x0 unchanged, HREADYOUT=1 next cycle.
- Halfword write @0x2 and @0x3:
  - With the macro: @0x3 gives the ERROR pair.
  - Without the macro: @0x3 writes lanes 2–3, OKAY.
